keccak_out_serializer: RTL and testbench

//  Digest serializer between the Keccak permutation core and the hash-output sink/file writer.
//  - Captures the rate portion of the final state.
//  - Emits the digest as 32-bit words with a valid/ready handshake.
//  - Requests extra permutations when a SHAKE output length exceeds one rate block.
//  - Drives finish_hash once the digest is complete.

---
 rtl/keccak_out_serializer.sv | 172 +++++++++++++++++
 tb/tb_keccak_out_serializer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_out_serializer.sv
// keccak_out_serializer
//
// Turns the rate portion of the final Keccak state into a stream of 32-bit
// digest words for the hash-output sink. For SHAKE modes whose requested
// output is longer than one rate block, it asks the permutation core for
// another squeeze and continues from the freshly permuted state.
//
// Ports
//   clk          in   1        clock, everything on posedge
//   rst          in   1        synchronous active-high reset
//   cmode        in   3        0..3 SHA3-224/256/384/512, 4 SHAKE128, 5 SHAKE256
//   d            in   D_W      SHAKE output length in bits
//   start        in   1        pulse, state_in holds the final absorbed state
//   state_in     in   STATE_W  rate lanes 0..20, bit 0 = lane0 bit0
//   perm_req     out  1        one-cycle request for one more permutation
//   perm_done    in   1        one-cycle pulse, state_in holds permuted state
//   dt_o_hash    out  DATA_W   current digest word
//   ready        out  1        dt_o_hash is valid
//   wr_en        in   1        sink accepts the word (transfer = ready && wr_en)
//   finish_hash  out  1        digest complete, held until the next start

module keccak_out_serializer #(
    parameter int DATA_W  = 32,
    parameter int STATE_W = 1344,
    parameter int D_W     = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         cmode,
    input  logic [D_W-1:0]     d,
    input  logic               start,
    input  logic [STATE_W-1:0] state_in,
    output logic               perm_req,
    input  logic               perm_done,
    output logic [DATA_W-1:0]  dt_o_hash,
    output logic               ready,
    input  logic               wr_en,
    output logic               finish_hash
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EMIT    = 3'd1,
        SQ_REQ  = 3'd2,
        SQ_WAIT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state_q;
    state_t next_state;

    logic [STATE_W-1:0] block_q;
    logic [5:0]         n_q;
    logic [5:0]         rw_q;
    logic [5:0]         sent_q;
    logic [5:0]         idx_q;

    logic [5:0]         n_sel;
    logic [5:0]         rw_sel;
    logic               start_accept;
    logic               xfer;
    logic               perm_cap;
    logic [DATA_W-1:0]  cur_word;

    // Total word count and words-per-block for the mode offered with start.
    // SHAKE lengths are truncated to whole words, so only d[10:5] matters.
    always_comb begin
        n_sel  = 6'd0;
        rw_sel = 6'd0;
        case (cmode)
            3'd0: begin n_sel = 6'd7;  rw_sel = 6'd36; end
            3'd1: begin n_sel = 6'd8;  rw_sel = 6'd34; end
            3'd2: begin n_sel = 6'd12; rw_sel = 6'd26; end
            3'd3: begin n_sel = 6'd16; rw_sel = 6'd18; end
            3'd4: begin n_sel = 6'(d >> 5); rw_sel = 6'd42; end
            3'd5: begin n_sel = 6'(d >> 5); rw_sel = 6'd34; end
            default: begin n_sel = 6'd0; rw_sel = 6'd0; end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state and output decode. Outputs are pure functions of the state,
    // which gives the one-cycle start->ready and perm_done->ready latency.
    always_comb begin
        next_state   = state_q;
        ready        = 1'b0;
        perm_req     = 1'b0;
        finish_hash  = 1'b0;
        start_accept = 1'b0;
        xfer         = 1'b0;
        perm_cap     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                finish_hash = (state_q == DONE);
                if (start) begin
                    start_accept = 1'b1;
                    next_state   = (n_sel == 6'd0) ? DONE : EMIT;
                end
            end
            EMIT: begin
                ready = 1'b1;
                if (wr_en) begin
                    xfer = 1'b1;
                    if (sent_q + 6'd1 == n_q) begin
                        next_state = DONE;
                    end else if (idx_q + 6'd1 == rw_q) begin
                        next_state = SQ_REQ;
                    end
                end
            end
            SQ_REQ: begin
                perm_req   = 1'b1;
                next_state = SQ_WAIT;
            end
            SQ_WAIT: begin
                if (perm_done) begin
                    perm_cap   = 1'b1;
                    next_state = EMIT;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Word counters and latched mode parameters.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q    <= 6'd0;
            rw_q   <= 6'd0;
            sent_q <= 6'd0;
            idx_q  <= 6'd0;
        end else if (start_accept) begin
            n_q    <= n_sel;
            rw_q   <= rw_sel;
            sent_q <= 6'd0;
            idx_q  <= 6'd0;
        end else if (xfer) begin
            sent_q <= sent_q + 6'd1;
            idx_q  <= idx_q + 6'd1;
        end else if (perm_cap) begin
            idx_q  <= 6'd0;
        end
    end

    // Captured rate block. Left unreset: it is only observable while in EMIT,
    // which can only be reached through a capture.
    always_ff @(posedge clk) begin
        if (start_accept || perm_cap) begin
            block_q <= state_in;
        end
    end

    // Select word idx and byte-swap it so state byte 0 leads on the bus.
    always_comb begin
        cur_word  = block_q[idx_q*DATA_W +: DATA_W];
        dt_o_hash = '0;
        if (ready) begin
            dt_o_hash = {cur_word[7:0], cur_word[15:8], cur_word[23:16], cur_word[31:24]};
        end
    end

endmodule

// File: tb/tb_keccak_out_serializer.sv
// tb_keccak_out_serializer
//
// Self-checking bench for keccak_out_serializer. A table of mode scenarios is
// run through one stimulus task that models the expected word stream; a few
// hand-written sequences cover reset, reset mid-digest and idle perm_done.

module tb_keccak_out_serializer;

    logic          clk;
    logic          rst;
    logic [2:0]    cmode;
    logic [10:0]   d;
    logic          start;
    logic [1343:0] state_in;
    logic          perm_req;
    logic          perm_done;
    logic [31:0]   dt_o_hash;
    logic          ready;
    logic          wr_en;
    logic          finish_hash;

    int n_compared;
    int n_mismatched;

    typedef struct {
        logic [2:0]  cm;
        logic [10:0] dd;
        int          n;
        int          rw;
        int          perms;
        bit          stall;
        bit          repulse;
    } scenario_t;

    scenario_t table_v [10];

    keccak_out_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .cmode       (cmode),
        .d           (d),
        .start       (start),
        .state_in    (state_in),
        .perm_req    (perm_req),
        .perm_done   (perm_done),
        .dt_o_hash   (dt_o_hash),
        .ready       (ready),
        .wr_en       (wr_en),
        .finish_hash (finish_hash)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block b holds byte value (k + 17*b) mod 256 at byte position k.
    function automatic logic [1343:0] make_state(input int b);
        logic [1343:0] s;
        s = '0;
        for (int k = 0; k < 168; k++) begin
            s[8*k +: 8] = 8'(k + 17*b);
        end
        return s;
    endfunction

    // Word w of block b on the bus: bytes 4w..4w+3, lowest byte in the MSBs.
    function automatic logic [31:0] expected_word(input int b, input int w);
        return {8'(4*w + 17*b), 8'(4*w + 1 + 17*b), 8'(4*w + 2 + 17*b), 8'(4*w + 3 + 17*b)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Runs one digest: start, then follow the stream cycle by cycle, serving
    // squeeze requests with perm_done five cycles later.
    task automatic applyStimulus(input scenario_t sc);
        int  words;
        int  nperm;
        int  blk;
        int  wib;
        int  wait_cnt;
        int  last_xfer;
        int  pd_cycle;
        bit  waiting;
        bit  finished;

        cmode    = sc.cm;
        d        = sc.dd;
        state_in = make_state(0);
        wr_en    = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cmode    = 3'd7;
        d        = '0;
        state_in = make_state(200);

        words = 0; nperm = 0; blk = 0; wib = 0; wait_cnt = 0;
        last_xfer = 0; pd_cycle = -10; waiting = 1'b0; finished = 1'b0;

        for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
            start     = 1'b0;
            perm_done = 1'b0;
            wr_en     = sc.stall ? cyc[0] : 1'b1;

            if (cyc == 1) begin
                checkOutput("first_ready", 32'(ready), 32'(sc.n > 0));
            end
            if (cyc == pd_cycle + 1) begin
                checkOutput("perm_done_to_ready", 32'(ready), 32'd1);
            end
            if (sc.repulse && cyc == 3) begin
                start    = 1'b1;
                cmode    = 3'd4;
                d        = 11'd2016;
                state_in = make_state(50);
            end

            if (finish_hash) begin
                finished = 1'b1;
                checkOutput("finish_latency", 32'(cyc), 32'(last_xfer + 1));
                checkOutput("finish_ready_low", 32'(ready), 32'd0);
                checkOutput("word_count", 32'(words), 32'(sc.n));
                checkOutput("perm_count", 32'(nperm), 32'(sc.perms));
            end else if (waiting) begin
                checkOutput("ready_low_in_squeeze", 32'(ready), 32'd0);
                wait_cnt--;
                if (wait_cnt == 0) begin
                    perm_done = 1'b1;
                    state_in  = make_state(blk + 1);
                    blk++;
                    wib       = 0;
                    pd_cycle  = cyc;
                    waiting   = 1'b0;
                end
            end else if (perm_req) begin
                nperm++;
                checkOutput("perm_at_block_end", 32'(wib), 32'(sc.rw));
                waiting  = 1'b1;
                wait_cnt = 5;
            end else if (ready) begin
                checkOutput("word", dt_o_hash, expected_word(blk, wib));
                if (wr_en) begin
                    words++;
                    wib++;
                    last_xfer = cyc;
                end
            end
            tick();
        end

        if (!finished) begin
            checkOutput("timeout_finish_hash", 32'd0, 32'd1);
        end
        start     = 1'b0;
        perm_done = 1'b0;
        wr_en     = 1'b0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;

        //             cmode  d          N   RW  perms stall repulse
        table_v[0] = '{3'd1, 11'd0,    8,  34, 0, 1'b0, 1'b0};
        table_v[1] = '{3'd3, 11'd0,    16, 18, 0, 1'b1, 1'b0};
        table_v[2] = '{3'd4, 11'd2016, 63, 42, 1, 1'b0, 1'b0};
        table_v[3] = '{3'd5, 11'd16,   0,  34, 0, 1'b0, 1'b0};
        table_v[4] = '{3'd2, 11'd0,    12, 26, 0, 1'b0, 1'b1};
        table_v[5] = '{3'd0, 11'd0,    7,  36, 0, 1'b0, 1'b0};
        table_v[6] = '{3'd5, 11'd1120, 35, 34, 1, 1'b1, 1'b0};
        table_v[7] = '{3'd5, 11'd1100, 34, 34, 0, 1'b0, 1'b0};
        table_v[8] = '{3'd6, 11'd0,    0,  0,  0, 1'b0, 1'b0};
        table_v[9] = '{3'd4, 11'd33,   1,  42, 0, 1'b0, 1'b0};

        rst       = 1'b1;
        cmode     = 3'd0;
        d         = '0;
        start     = 1'b0;
        state_in  = '0;
        perm_done = 1'b0;
        wr_en     = 1'b0;
        repeat (3) tick();
        checkOutput("reset_ready", 32'(ready), 32'd0);
        checkOutput("reset_perm_req", 32'(perm_req), 32'd0);
        checkOutput("reset_finish", 32'(finish_hash), 32'd0);
        checkOutput("reset_data", dt_o_hash, 32'd0);
        rst = 1'b0;
        tick();

        // A stray perm_done while idle must not start anything.
        perm_done = 1'b1;
        tick();
        perm_done = 1'b0;
        tick();
        checkOutput("idle_perm_done_ready", 32'(ready), 32'd0);
        checkOutput("idle_perm_done_finish", 32'(finish_hash), 32'd0);

        for (int i = 0; i < 10; i++) begin
            $display("[TB] scenario %0d: cmode=%0d d=%0d", i, table_v[i].cm, table_v[i].dd);
            applyStimulus(table_v[i]);
            if (i == 0) begin
                repeat (3) tick();
                checkOutput("finish_held", 32'(finish_hash), 32'd1);
                checkOutput("done_ready_low", 32'(ready), 32'd0);
            end
        end

        // Reset in the middle of a SHA3-224 digest, then a clean rerun.
        $display("[TB] reset mid-digest");
        cmode    = 3'd0;
        state_in = make_state(0);
        wr_en    = 1'b1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("pre_reset_word", dt_o_hash, expected_word(0, i));
            tick();
        end
        rst = 1'b1;
        tick();
        checkOutput("mid_reset_ready", 32'(ready), 32'd0);
        checkOutput("mid_reset_finish", 32'(finish_hash), 32'd0);
        checkOutput("mid_reset_data", dt_o_hash, 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("post_reset_ready", 32'(ready), 32'd0);
        applyStimulus(table_v[5]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
